// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle control FSM that steps the execute datapath one instruction at a
// time. Each step_tick (accepted only while idle) fetches a 32-bit instruction
// as four byte reads from the shared program memory (big-endian: the byte at pc
// becomes instr[31:24]), offers it to the datapath with a valid/ready
// handshake, lends the memory read port to the datapath for loads while it
// executes, and finally advances pc (pc+4 or a redirect target) and instret.
// A misaligned or out-of-range pc at step time parks the sequencer in a sticky
// fault state that only reset clears.
//
// Ports:
//   clk          core clock
//   reset        asynchronous active-low reset
//   step_tick    one-cycle pulse allowing the next instruction to start
//   mem_addr     shared memory read address
//   mem_rd       shared memory read strobe
//   mem_rdata    read data, valid one cycle after mem_rd
//   instr        assembled instruction
//   instr_valid  instruction offered to the datapath
//   instr_ready  datapath accepts instr
//   ex_req       datapath load-byte request (honoured only while executing)
//   ex_req_addr  load address
//   ex_rdata     load data, qualified by ex_rvalid
//   ex_rvalid    load data valid
//   ex_done      datapath finished the current instruction
//   ex_redirect  with ex_done: next pc is ex_target
//   ex_target    redirect target
//   pc           address of the current/next instruction
//   instret      retired-instruction count (wraps)
//   fault        sticky fetch fault
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int PC_W      = 8,
  parameter int MEM_BYTES = 72
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step_tick,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  input  logic [7:0]      mem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            ex_req,
  input  logic [PC_W-1:0] ex_req_addr,
  output logic [7:0]      ex_rdata,
  output logic            ex_rvalid,
  input  logic            ex_done,
  input  logic            ex_redirect,
  input  logic [PC_W-1:0] ex_target,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     instret,
  output logic            fault
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_EXEC,
    ST_FAULT
  } state_t;

  // Range check is done one bit wider than pc so pc+3 cannot wrap into range.
  localparam logic [PC_W:0] MEM_LIMIT   = (PC_W+1)'(MEM_BYTES);
  localparam logic [2:0]    LAST_FETCH_K = 3'd4;

  state_t          state_reg, state_next;
  logic [2:0]      k_reg, k_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [15:0]     instret_reg, instret_next;
  logic            ex_rvalid_reg;
  logic            ex_grant;
  logic            fetch_ok;

  assign fetch_ok = (pc_reg[1:0] == 2'b00) &&
                    (({1'b0, pc_reg} + (PC_W+1)'(3)) < MEM_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      k_reg         <= '0;
      pc_reg        <= '0;
      instret_reg   <= '0;
      ex_rvalid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      pc_reg        <= pc_next;
      instret_reg   <= instret_next;
      // Only reads granted to the datapath produce ex_rvalid; fetch reads don't.
      ex_rvalid_reg <= ex_grant;
    end
  end

  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    pc_next      = pc_reg;
    instret_next = instret_reg;
    mem_rd       = 1'b0;
    mem_addr     = '0;
    instr_valid  = 1'b0;
    fault        = 1'b0;
    ex_grant     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (step_tick) begin
          if (fetch_ok) begin
            state_next = ST_FETCH;
            k_next     = '0;
          end else begin
            state_next = ST_FAULT;
          end
        end
      end

      ST_FETCH: begin
        // k=0..3 issue reads; k=1..4 capture the byte returned for k-1.
        if (k_reg < LAST_FETCH_K) begin
          mem_rd   = 1'b1;
          mem_addr = pc_reg + PC_W'(k_reg);
          k_next   = k_reg + 3'd1;
        end else begin
          state_next = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // A load request coinciding with completion is dropped.
        ex_grant = ex_req & ~ex_done;
        mem_rd   = ex_grant;
        mem_addr = ex_req_addr;
        if (ex_done) begin
          pc_next      = ex_redirect ? ex_target : (pc_reg + PC_W'(4));
          instret_next = instret_reg + 16'd1;
          state_next   = ST_IDLE;
        end
      end

      ST_FAULT: begin
        fault = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // One capture register per byte lane; lane gi is filled on fetch step gi+1.
  // The bytes are left untouched outside FETCH so instr stays stable.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] byte_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          byte_reg <= 8'h00;
        end else if (state_reg == ST_FETCH && k_reg == 3'(gi + 1)) begin
          byte_reg <= mem_rdata;
        end
      end

      assign instr[31-8*gi -: 8] = byte_reg;
    end
  endgenerate

  assign pc        = pc_reg;
  assign instret   = instret_reg;
  assign ex_rvalid = ex_rvalid_reg;
  assign ex_rdata  = ex_rvalid_reg ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed testbench for instr_sequencer. A behavioural model describes the
// sequencer as phases (waiting / reading / offering / running / halted) and
// derives the instruction straight from the memory image; a compare process
// checks every DUT output against it on each falling edge. Literal checks in
// the stimulus pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int PC_W      = 8;
  localparam int MEM_BYTES = 72;

  logic            clk;
  logic            reset;
  logic            step_tick;
  logic [PC_W-1:0] mem_addr;
  logic            mem_rd;
  logic [7:0]      mem_rdata;
  logic [31:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic            ex_req;
  logic [PC_W-1:0] ex_req_addr;
  logic [7:0]      ex_rdata;
  logic            ex_rvalid;
  logic            ex_done;
  logic            ex_redirect;
  logic [PC_W-1:0] ex_target;
  logic [PC_W-1:0] pc;
  logic [15:0]     instret;
  logic            fault;

  int n_cmp = 0;
  int n_err = 0;

  instr_sequencer #(.PC_W(PC_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk         (clk),
    .reset       (reset),
    .step_tick   (step_tick),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ex_req      (ex_req),
    .ex_req_addr (ex_req_addr),
    .ex_rdata    (ex_rdata),
    .ex_rvalid   (ex_rvalid),
    .ex_done     (ex_done),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .pc          (pc),
    .instret     (instret),
    .fault       (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program/data memory: one-cycle read latency.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    mem_rdata <= mem_rd ? mem[mem_addr] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef enum {WAITING, READING, OFFERING, RUNNING, HALTED} phase_t;

  phase_t      ph            = WAITING;
  int          age           = 0;      // cycles spent reading so far
  int          m_pc          = 0;
  int          m_instret     = 0;
  logic [31:0] m_instr       = 32'h0;
  bit          m_instr_known = 1'b1;
  bit          m_rvalid      = 1'b0;
  int          m_rdaddr      = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph            = WAITING;
      age           = 0;
      m_pc          = 0;
      m_instret     = 0;
      m_instr       = 32'h0;
      m_instr_known = 1'b1;
      m_rvalid      = 1'b0;
      m_rdaddr      = 0;
    end else begin
      m_rvalid = (ph == RUNNING) && ex_req && !ex_done;
      m_rdaddr = int'(ex_req_addr);
      case (ph)
        WAITING: begin
          if (step_tick) begin
            if ((m_pc % 4) != 0 || m_pc + 3 >= MEM_BYTES) begin
              ph = HALTED;
              $display("step: pc=%0d rejected, fault", m_pc);
            end else begin
              ph            = READING;
              age           = 0;
              m_instr_known = 1'b0;
            end
          end
        end
        READING: begin
          age++;
          if (age == 5) begin
            ph            = OFFERING;
            m_instr       = {mem[m_pc], mem[m_pc+1], mem[m_pc+2], mem[m_pc+3]};
            m_instr_known = 1'b1;
          end
        end
        OFFERING: begin
          if (instr_ready) ph = RUNNING;
        end
        RUNNING: begin
          if (ex_done) begin
            $display("retire: pc=%0d instr=0x%08h redirect=%0b next_pc=%0d",
                     m_pc, m_instr, ex_redirect,
                     ex_redirect ? int'(ex_target) : (m_pc + 4) % 256);
            m_pc      = ex_redirect ? int'(ex_target) : (m_pc + 4) % 256;
            m_instret = (m_instret + 1) % 65536;
            ph        = WAITING;
          end
        end
        default: ;
      endcase
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    logic        exp_rd;
    logic [7:0]  exp_addr;
    exp_rd   = ((ph == READING) && age < 4) || ((ph == RUNNING) && ex_req && !ex_done);
    exp_addr = (ph == READING) ? 8'(m_pc + age) : ex_req_addr;
    check("mem_rd", {31'b0, mem_rd}, {31'b0, exp_rd});
    if (exp_rd) check("mem_addr", {24'b0, mem_addr}, {24'b0, exp_addr});
    check("instr_valid", {31'b0, instr_valid}, {31'b0, ph == OFFERING});
    if (m_instr_known) check("instr", instr, m_instr);
    check("pc", {24'b0, pc}, 32'(m_pc));
    check("instret", {16'b0, instret}, 32'(m_instret));
    check("fault", {31'b0, fault}, {31'b0, ph == HALTED});
    check("ex_rvalid", {31'b0, ex_rvalid}, {31'b0, m_rvalid});
    check("ex_rdata", {24'b0, ex_rdata}, m_rvalid ? {24'b0, mem[m_rdaddr]} : 32'h0);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one full instruction with ready high and completion on the first
  // execute cycle; checks the offered instruction against a literal.
  task automatic run_instr(input logic [31:0] exp_instr, input logic redir,
                           input logic [7:0] tgt);
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
    repeat (5) step();
    check("lit_instr_valid", {31'b0, instr_valid}, 32'h1);
    check("lit_instr", instr, exp_instr);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    ex_done     = 1'b1;
    ex_redirect = redir;
    ex_target   = tgt;
    step();
    ex_done     = 1'b0;
    ex_redirect = 1'b0;
    ex_target   = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    {mem[0], mem[1], mem[2], mem[3]}     = 32'h00A00093;
    {mem[4], mem[5], mem[6], mem[7]}     = 32'h12345678;
    mem[8'h10]                           = 8'h5A;
    {mem[68], mem[69], mem[70], mem[71]} = 32'hDEADBEEF;

    reset = 1'b0; step_tick = 1'b0; instr_ready = 1'b0;
    ex_req = 1'b0; ex_req_addr = '0; ex_done = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    repeat (2) step();
    check("lit_reset_pc", {24'b0, pc}, 32'h0);
    check("lit_reset_instret", {16'b0, instret}, 32'h0);
    check("lit_reset_instr", instr, 32'h0);
    check("lit_reset_fault", {31'b0, fault}, 32'h0);
    check("lit_reset_mem_rd", {31'b0, mem_rd}, 32'h0);
    reset = 1'b1;
    step();

    // Basic fetch: four byte reads, offer six cycles after the tick.
    instr_ready = 1'b1;
    step_tick   = 1'b1;
    step();
    step_tick = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("lit_fetch_rd", {31'b0, mem_rd}, 32'h1);
      check("lit_fetch_addr", {24'b0, mem_addr}, 32'(k));
      step();
    end
    check("lit_fetch_k4_rd", {31'b0, mem_rd}, 32'h0);
    step();
    check("lit_t1_valid", {31'b0, instr_valid}, 32'h1);
    check("lit_t1_instr", instr, 32'h00A00093);
    step();
    check("lit_t1_exec_valid", {31'b0, instr_valid}, 32'h0);
    ex_done = 1'b1;
    step();
    ex_done = 1'b0;
    check("lit_t1_pc", {24'b0, pc}, 32'h4);
    check("lit_t1_instret", {16'b0, instret}, 32'h1);

    // Back-pressure: ready low for 10 cycles while ticks pulse.
    instr_ready = 1'b0;
    step_tick   = 1'b1;
    step();
    step_tick = 1'b0;
    repeat (5) step();
    for (int i = 0; i < 10; i++) begin
      check("lit_wait_valid", {31'b0, instr_valid}, 32'h1);
      check("lit_wait_instr", instr, 32'h12345678);
      check("lit_wait_rd", {31'b0, mem_rd}, 32'h0);
      step_tick = (i % 3 == 0);
      step();
    end
    step_tick   = 1'b0;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("lit_exec_entry_valid", {31'b0, instr_valid}, 32'h0);

    // Load through the granted port.
    ex_req      = 1'b1;
    ex_req_addr = 8'h10;
    #1;
    check("lit_load_addr", {24'b0, mem_addr}, 32'h10);
    check("lit_load_rd", {31'b0, mem_rd}, 32'h1);
    step();
    ex_req = 1'b0;
    check("lit_load_rvalid", {31'b0, ex_rvalid}, 32'h1);
    check("lit_load_rdata", {24'b0, ex_rdata}, 32'h5A);

    // Request together with done is dropped; a tick at the same edge is ignored.
    ex_req      = 1'b1;
    ex_req_addr = 8'h11;
    ex_done     = 1'b1;
    ex_redirect = 1'b1;
    ex_target   = 8'h00;
    step_tick   = 1'b1;
    #1;
    check("lit_req_with_done_rd", {31'b0, mem_rd}, 32'h0);
    step();
    ex_done = 1'b0; ex_redirect = 1'b0; step_tick = 1'b0;
    check("lit_redirect_pc", {24'b0, pc}, 32'h0);
    check("lit_instret2", {16'b0, instret}, 32'h2);
    ex_req_addr = 8'h20;
    #1;
    check("lit_idle_req_rd", {31'b0, mem_rd}, 32'h0);
    step();
    ex_req = 1'b0;
    check("lit_idle_req_rvalid", {31'b0, ex_rvalid}, 32'h0);
    check("lit_no_refetch_rd", {31'b0, mem_rd}, 32'h0);
    step();

    // Fetch from redirected pc 0, then redirect to misaligned 6 -> fault.
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
    check("lit_refetch_addr", {24'b0, mem_addr}, 32'h0);
    repeat (5) step();
    check("lit_refetch_instr", instr, 32'h00A00093);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    ex_done = 1'b1; ex_redirect = 1'b1; ex_target = 8'h06;
    step();
    ex_done = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    check("lit_misaligned_pc", {24'b0, pc}, 32'h6);
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
    check("lit_misaligned_fault", {31'b0, fault}, 32'h1);
    check("lit_misaligned_rd", {31'b0, mem_rd}, 32'h0);
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
    step();
    check("lit_fault_sticky", {31'b0, fault}, 32'h1);
    check("lit_fault_pc_frozen", {24'b0, pc}, 32'h6);
    reset = 1'b0;
    #1;
    check("lit_fault_reset", {31'b0, fault}, 32'h0);
    check("lit_fault_reset_pc", {24'b0, pc}, 32'h0);
    step();
    reset = 1'b1;
    step();

    // Last legal word at 68, then pc 72 is out of range.
    run_instr(32'h00A00093, 1'b1, 8'd68);
    check("lit_pc68", {24'b0, pc}, 32'd68);
    run_instr(32'hDEADBEEF, 1'b0, 8'd0);
    check("lit_pc72", {24'b0, pc}, 32'd72);
    check("lit_instret_end", {16'b0, instret}, 32'h2);
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
    check("lit_range_fault", {31'b0, fault}, 32'h1);
    check("lit_range_rd", {31'b0, mem_rd}, 32'h0);

    // Reset in the middle of a fetch.
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    run_instr(32'h00A00093, 1'b0, 8'd0);
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
    step();
    step();
    check("lit_k2_addr", {24'b0, mem_addr}, 32'h6);
    #3;
    reset = 1'b0;
    #1;
    check("lit_abort_rd", {31'b0, mem_rd}, 32'h0);
    check("lit_abort_addr", {24'b0, mem_addr}, 32'h0);
    check("lit_abort_pc", {24'b0, pc}, 32'h0);
    check("lit_abort_instret", {16'b0, instret}, 32'h0);
    check("lit_abort_instr", instr, 32'h0);
    check("lit_abort_valid", {31'b0, instr_valid}, 32'h0);
    step();
    reset = 1'b1;
    step();
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
    check("lit_after_abort_addr", {24'b0, mem_addr}, 32'h0);
    check("lit_after_abort_rd", {31'b0, mem_rd}, 32'h1);
    repeat (5) step();
    check("lit_after_abort_instr", instr, 32'h00A00093);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    ex_done = 1'b1;
    step();
    ex_done = 1'b0;
    check("lit_after_abort_pc", {24'b0, pc}, 32'h4);
    check("lit_after_abort_instret", {16'b0, instret}, 32'h1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
